id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CTRL_W, default 22, width of the decoded control word.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_ctrl  in  CTRL_W  decoded control word from the control unit
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs_val, id_rt_val  in  32 each  register-file read data
- id_imm16  in  16  instruction[15:0]
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- flush  in  1  branch/jump taken; kill the ID instruction
- ex_ctrl  out  CTRL_W  registered control word to EX
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_a, ex_b  out  32 each  registered PC, rs value, rt value
- ex_imm16  out  16  registered immediate
- ex_dest  out  5  registered destination register
- stall_if_id  out  1  hold PC and IF/ID register this cycle
- stall_cnt, flush_cnt  out  16 each  saturating event counters

Function
REQ-003 Control word layout: [21] cond/uncond, [20] r31, [19] uncond jump, [18] destination, [17:15] source operand, [14:11] ALU op, [10] load, [9] RF enable, [8] branch, [7] target-address, [6:5] mem size, [4] mem R/W, [3] mem SE, [2] HI en, [1] LO en, [0] mem enable.
REQ-004 Destination: ctrl[20]&ctrl[19] -> 31; else ctrl[20] -> id_rt; else id_rd; computed in ID, registered into ex_dest.
REQ-005 Load-use hazard (combinational) = ex_valid & ex_ctrl[0] & ~ex_ctrl[4] & (ex_dest != 0) & id_valid & ((ex_dest == id_rs) | (ex_dest == id_rt)).
REQ-006 stall_if_id = hazard & ~flush, combinational, same cycle.
REQ-007 Each rising edge, priority: flush -> bubble; else hazard -> bubble; else capture all id_* fields, ex_valid <= id_valid.
REQ-008 Bubble: ex_ctrl <= 0, ex_valid <= 0, ex_dest <= 0; data fields (ex_pc, ex_a, ex_b, ex_imm16) hold previous value.
REQ-009 id_valid = 0 without flush/hazard: capture as normal but force ex_ctrl to 0.
REQ-010 Latency: one cycle ID -> EX; a hazard inserts exactly one bubble (bubble clears ex_valid, so hazard self-clears next cycle).
REQ-011 Simultaneous flush and hazard: bubble, stall_if_id = 0, only flush_cnt increments.
REQ-012 stall_cnt increments on each cycle with stall_if_id = 1; flush_cnt on each cycle with flush = 1 & id_valid = 1; both saturate at 16'hFFFF, no wrap.
REQ-013 No register changes on cycles without a rising clk edge; ex_* outputs driven only from flops.

Reset
REQ-014 rst_n low asynchronously forces all ex_* outputs, stall_cnt, flush_cnt to 0; stall_if_id reads 0 while in reset.
REQ-015 Reset mid-hazard discards the pending stall; first edge after release captures ID normally.

Structure
REQ-016 Shared package ppu_pkg holds CTRL_W, control-word bit positions (REQ-003), and register 31 constant.
REQ-017 One sub-module ppu_hazard_detect implements REQ-005/REQ-006 combinationally; counters and pipeline register stay in id_ex_stage.

Verification
REQ-018 Pass-through: id_ctrl=22'h0C0600, id_pc=32'h40, id_rs_val=5, id_valid=1 -> next edge ex_ctrl=22'h0C0600, ex_pc=32'h40, ex_a=5, ex_valid=1.
REQ-019 Load-use: EX holds LW (ctrl[0]=1, ctrl[4]=0) ex_dest=8; ID id_rs=8 -> stall_if_id=1 same cycle, next edge ex_ctrl=0, ex_valid=0, stall_cnt=1; following edge captures ID instruction.
REQ-020 No hazard on $0 or store: EX SW (ctrl[4]=1) dest=8 or LW dest=0, ID rs=8/0 -> stall_if_id=0.
REQ-021 Flush+hazard same cycle -> stall_if_id=0, bubble, flush_cnt=1, stall_cnt=0.
REQ-022 Destination: JAL ctrl (bits 20,19 set) -> ex_dest=31; ADDIU id_rt=9 -> 9; SUBU id_rd=12 -> 12.
REQ-023 Saturation and reset: force 65540 stall cycles -> stall_cnt=16'hFFFF; assert rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: constants shared by the ID/EX pipeline stage.
//   CTRL_W        - width of the decoded control word
//   CB_*          - bit positions inside the control word
//   REG_RA        - link register ($31) written by JAL-style jumps
//   ex_data_t     - data payload carried from ID to EX
//   dest_sel()    - destination register selection from control bits
//   sat_inc16()   - 16-bit saturating increment for event counters
package ppu_pkg;

   localparam int CTRL_W = 22;

   // Control word bit positions
   localparam int CB_COND     = 21;  // conditional / unconditional
   localparam int CB_R31      = 20;  // together with CB_UJMP selects $31
   localparam int CB_UJMP     = 19;  // unconditional jump
   localparam int CB_DEST     = 18;  // destination select
   localparam int CB_SRC_HI   = 17;  // source operand select [17:15]
   localparam int CB_SRC_LO   = 15;
   localparam int CB_ALU_HI   = 14;  // ALU op [14:11]
   localparam int CB_ALU_LO   = 11;
   localparam int CB_LOAD     = 10;
   localparam int CB_RF_EN    = 9;
   localparam int CB_BRANCH   = 8;
   localparam int CB_TGT      = 7;   // target-address select
   localparam int CB_MSIZE_HI = 6;   // memory access size [6:5]
   localparam int CB_MSIZE_LO = 5;
   localparam int CB_MEM_RW   = 4;   // 0 = read, 1 = write
   localparam int CB_MEM_SE   = 3;   // sign-extend load data
   localparam int CB_HI_EN    = 2;
   localparam int CB_LO_EN    = 1;
   localparam int CB_MEM_EN   = 0;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [4:0]  REG_RA   = 5'd31;
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm16;
   } ex_data_t;

   // r31 & ujmp -> $31 (link), r31 alone -> rt (I-type), otherwise rd.
   function automatic logic [4:0] dest_sel(input logic       r31,
                                           input logic       ujmp,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
      logic [4:0] d;
      if (r31 && ujmp) d = REG_RA;
      else if (r31)    d = rt;
      else             d = rd;
      return d;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ppu_hazard_detect.sv
// ppu_hazard_detect: combinational load-use hazard detection.
//   ex_valid, ex_mem_en, ex_mem_rw, ex_dest - instruction currently in EX
//   id_valid, id_rs, id_rt                  - instruction currently in ID
//   flush                                   - ID instruction is being killed
//   hazard                                  - raw load-use condition
//   stall                                   - hold PC and IF/ID this cycle
module ppu_hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_en,
   input  logic       ex_mem_rw,
   input  logic [4:0] ex_dest,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       flush,
   output logic       hazard,
   output logic       stall
);
   import ppu_pkg::*;

   logic ex_is_load;
   logic src_match;

   // A memory read in EX whose data is not available until MEM.
   // Writes to $0 are never real dependencies.
   assign ex_is_load = ex_valid & ex_mem_en & ~ex_mem_rw & (ex_dest != REG_ZERO);
   assign src_match  = (ex_dest == id_rs) | (ex_dest == id_rt);
   assign hazard     = ex_is_load & id_valid & src_match;
   // A flush already kills the dependent instruction, so no stall is needed.
   assign stall      = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and flush.
//   clk, rst_n     - clock, asynchronous active-low reset
//   id_*           - decoded instruction fields from ID
//   flush          - kill the ID instruction (taken branch/jump)
//   ex_*           - registered instruction fields for EX
//   stall_if_id    - hold PC and IF/ID register this cycle
//   stall_cnt      - saturating count of stall cycles
//   flush_cnt      - saturating count of flushed valid instructions
module id_ex_stage #(
   parameter int CTRL_W = 22
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [31:0]       id_rs_val,
   input  logic [31:0]       id_rt_val,
   input  logic [15:0]       id_imm16,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              flush,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_a,
   output logic [31:0]       ex_b,
   output logic [15:0]       ex_imm16,
   output logic [4:0]        ex_dest,
   output logic              stall_if_id,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
);
   import ppu_pkg::*;

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   ex_data_t          data_q, data_d;
   logic [4:0]        dest_q, dest_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic [15:0]       flush_cnt_q, flush_cnt_d;

   logic hazard;
   logic stall;

   ppu_hazard_detect u_hazard (
      .ex_valid  (valid_q),
      .ex_mem_en (ctrl_q[CB_MEM_EN]),
      .ex_mem_rw (ctrl_q[CB_MEM_RW]),
      .ex_dest   (dest_q),
      .id_valid  (id_valid),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .flush     (flush),
      .hazard    (hazard),
      .stall     (stall)
   );

   always_comb begin
      ctrl_d      = ctrl_q;
      valid_d     = valid_q;
      data_d      = data_q;
      dest_d      = dest_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (flush || hazard) begin
         // Bubble: control and destination cleared; data fields keep their
         // old value since nothing downstream looks at them without valid.
         ctrl_d  = '0;
         valid_d = 1'b0;
         dest_d  = REG_ZERO;
      end else begin
         // An empty ID slot still moves data along, but must carry no
         // side-effecting control bits into EX.
         ctrl_d       = id_valid ? id_ctrl : '0;
         valid_d      = id_valid;
         data_d.pc    = id_pc;
         data_d.a     = id_rs_val;
         data_d.b     = id_rt_val;
         data_d.imm16 = id_imm16;
         dest_d       = dest_sel(id_ctrl[CB_R31], id_ctrl[CB_UJMP], id_rt, id_rd);
      end

      if (stall)
         stall_cnt_d = sat_inc16(stall_cnt_q);
      if (flush && id_valid)
         flush_cnt_d = sat_inc16(flush_cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q      <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         dest_q      <= REG_ZERO;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         dest_q      <= dest_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_ctrl     = ctrl_q;
   assign ex_valid    = valid_q;
   assign ex_pc       = data_q.pc;
   assign ex_a        = data_q.a;
   assign ex_b        = data_q.b;
   assign ex_imm16    = data_q.imm16;
   assign ex_dest     = dest_q;
   // valid_q is cleared in reset, so this already reads 0 while rst_n is low.
   assign stall_if_id = stall;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
